// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one registered-address sprite ROM among NUM_REQ
// draw requesters in the vga_clk domain. It issues one grant per cycle by
// round-robin, drives the winner's address to the ROM, and returns the ROM
// word tagged with the requester id ROM_LAT+1 cycles after the grant.
// Optional build macro SPRITE_ARB_PRIO0_EN: requester 0 always wins when it
// is eligible. Requesters 1..NUM_REQ-1 round-robin among themselves.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 4,
  parameter int ROM_LAT = 1,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_q,
  output logic                      rd_valid,
  output logic [ID_W-1:0]           rd_id,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      busy
);

  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]    last;
  logic [NUM_REQ-1:0] elig;
  logic [ID_W:0]      pick;
  logic               win_vld;
  logic [ID_W-1:0]    win_id;
  logic               upd_last;
  logic               fire;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [ADDR_W-1:0]  addr_sel;
  logic [ROM_LAT:0]   vld_nxt;
  logic [ROM_LAT:0]   vld_p;
  logic [ID_W-1:0]    id_p [ROM_LAT+1];

  // First eligible index after ptr, searching ptr+1, ptr+2, ... modulo NUM_REQ.
  // Result is {found, index}. Walking the offsets from far to near lets the
  // nearest candidate overwrite the others.
  function automatic logic [ID_W:0] pick_rr(input logic [NUM_REQ-1:0] el,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0] res;
    int            cand;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (el[ID_W'(cand)]) res = {1'b1, ID_W'(cand)};
    end
    return res;
  endfunction

`ifdef SPRITE_ARB_PRIO0_EN
  // Round-robin restricted to indices 1..NUM_REQ-1; ptr is always in that range.
  function automatic logic [ID_W:0] pick_rr_hi(input logic [NUM_REQ-1:0] el,
                                               input logic [ID_W-1:0]    ptr);
    logic [ID_W:0] res;
    int            cand;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 1; k--) begin
      cand = ((int'(ptr) - 1 + k) % (NUM_REQ - 1)) + 1;
      if (el[ID_W'(cand)]) res = {1'b1, ID_W'(cand)};
    end
    return res;
  endfunction
`endif

  // Arbitration: the requester granted this cycle is masked out so a level
  // request held through its gnt cycle is not granted twice.
  always_comb begin
    elig     = req & ~gnt;
    pick     = '0;
    win_vld  = 1'b0;
    win_id   = '0;
    upd_last = 1'b0;
`ifdef SPRITE_ARB_PRIO0_EN
    if (elig[0]) begin
      win_vld = 1'b1;
    end else begin
      pick     = pick_rr_hi(elig, last);
      win_vld  = pick[ID_W];
      win_id   = pick[ID_W-1:0];
      upd_last = pick[ID_W];
    end
`else
    pick     = pick_rr(elig, last);
    win_vld  = pick[ID_W];
    win_id   = pick[ID_W-1:0];
    upd_last = pick[ID_W];
`endif
    fire = en & win_vld;
  end

  always_comb begin
    gnt_nxt  = '0;
    addr_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == ID_W'(i)) begin
        addr_sel = req_addr[i*ADDR_W +: ADDR_W];
        if (fire) gnt_nxt[i] = 1'b1;
      end
    end
    vld_nxt    = '0;
    vld_nxt[0] = fire;
    for (int k = 1; k <= ROM_LAT; k++) begin
      vld_nxt[k] = vld_p[k-1];
    end
  end

  // Stage p0: grant pulse, ROM address and round-robin pointer.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt         <= '0;
      rom_address <= '0;
      last        <= LAST_RST;
    end else begin
      gnt <= gnt_nxt;
      if (fire) begin
        rom_address <= addr_sel;
        if (upd_last) last <= win_id;
      end
    end
  end

  // Stages p1..pROM_LAT: tag valid bits track the ROM latency.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p <= '0;
    end else begin
      vld_p <= vld_nxt;
    end
  end

  always_ff @(posedge vga_clk) begin
    id_p[0] <= win_id;
    for (int k = 1; k <= ROM_LAT; k++) begin
      id_p[k] <= id_p[k-1];
    end
  end

  // Output stage: capture rom_q alongside the tag leaving the pipeline.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_id    <= '0;
      rd_data  <= '0;
      busy     <= 1'b0;
    end else begin
      rd_valid <= vld_p[ROM_LAT];
      busy     <= |vld_nxt;
      if (vld_p[ROM_LAT]) begin
        rd_id   <= id_p[ROM_LAT];
        rd_data <= rom_q;
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: one instance with ROM_LAT=1 and one
// with ROM_LAT=3 share clock, reset and request inputs; each has its own
// registered ROM model returning addr[3:0]^4'h6.
module tb_sprite_rom_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 4;
  localparam int ID_W    = 2;
  localparam int NV      = 29;

  logic                      vga_clk = 1'b0;
  logic                      reset_n;
  logic                      en;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;

  logic [NUM_REQ-1:0] gnt1, gnt3;
  logic [ADDR_W-1:0]  addr1, addr3;
  logic [DATA_W-1:0]  q1, q3;
  logic               vld1, vld3;
  logic [ID_W-1:0]    id1, id3;
  logic [DATA_W-1:0]  dat1, dat3;
  logic               busy1, busy3;
  logic [DATA_W-1:0]  rom3_s [3];

  int n_tests = 0;
  int n_fail  = 0;

  // Requester addresses and the ROM words they map to (a[3:0]^6).
  logic [ADDR_W-1:0] addr_tab [4];
  logic [DATA_W-1:0] dat_tab  [4];
  int                seq_a    [12];

  typedef struct {
    logic        en;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [16:0] addr;
    logic        vld;
    logic [1:0]  id;
    logic [3:0]  dat;
    logic        busy;
  } vec_t;

  vec_t vt [NV];

  always #5 vga_clk = ~vga_clk;

  assign req_addr = {17'h00033, 17'h00A5F, 17'h00021, 17'h00010};

  function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
    return a[3:0] ^ 4'h6;
  endfunction

  always @(posedge vga_clk) q1 <= rom_f(addr1);

  always @(posedge vga_clk) begin
    rom3_s[0] <= rom_f(addr3);
    rom3_s[1] <= rom3_s[0];
    rom3_s[2] <= rom3_s[1];
  end
  assign q3 = rom3_s[2];

  sprite_rom_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(1)) u_dut1 (
    .vga_clk(vga_clk), .reset_n(reset_n), .en(en), .req(req), .req_addr(req_addr),
    .gnt(gnt1), .rom_address(addr1), .rom_q(q1), .rd_valid(vld1), .rd_id(id1),
    .rd_data(dat1), .busy(busy1)
  );

  sprite_rom_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(3)) u_dut3 (
    .vga_clk(vga_clk), .reset_n(reset_n), .en(en), .req(req), .req_addr(req_addr),
    .gnt(gnt3), .rom_address(addr3), .rom_q(q3), .rd_valid(vld3), .rd_id(id3),
    .rd_data(dat3), .busy(busy3)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic e, input logic [3:0] r, input logic [3:0] g,
                              input logic [16:0] a, input logic v, input logic [1:0] i,
                              input logic [3:0] d, input logic b);
    vec_t t;
    t.en = e; t.req = r; t.gnt = g; t.addr = a;
    t.vld = v; t.id = i; t.dat = d; t.busy = b;
    return t;
  endfunction

  task automatic pulse_reset();
    req     = '0;
    en      = 1'b1;
    reset_n = 1'b0;
    @(negedge vga_clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    addr_tab = '{17'h00010, 17'h00021, 17'h00A5F, 17'h00033};
    dat_tab  = '{4'h6, 4'h7, 4'h9, 4'h5};
`ifdef SPRITE_ARB_PRIO0_EN
    seq_a = '{0, 1, 0, 2, 0, 3, 0, 1, 0, 2, 0, 3};
`else
    seq_a = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
`endif

    // en, req, gnt, rom_address, rd_valid, rd_id, rd_data, busy (after the edge)
    for (int i = 0; i < 10; i++) vt[i] = mk(1, 4'b0000, 4'b0000, 17'h00000, 0, 0, 0, 0);
    vt[10] = mk(1, 4'b0100, 4'b0100, 17'h00A5F, 0, 0, 0, 1);
    vt[11] = mk(1, 4'b0000, 4'b0000, 17'h00A5F, 0, 0, 0, 1);
    vt[12] = mk(1, 4'b0000, 4'b0000, 17'h00A5F, 1, 2, 4'h9, 0);
    vt[13] = mk(1, 4'b0000, 4'b0000, 17'h00A5F, 0, 0, 0, 0);
    vt[14] = mk(0, 4'b0001, 4'b0000, 17'h00A5F, 0, 0, 0, 0);
    vt[15] = mk(1, 4'b0001, 4'b0001, 17'h00010, 0, 0, 0, 1);
    vt[16] = mk(1, 4'b0001, 4'b0000, 17'h00010, 0, 0, 0, 1);
    vt[17] = mk(1, 4'b0001, 4'b0001, 17'h00010, 1, 0, 4'h6, 1);
    vt[18] = mk(1, 4'b0000, 4'b0000, 17'h00010, 0, 0, 0, 1);
    vt[19] = mk(1, 4'b0000, 4'b0000, 17'h00010, 1, 0, 4'h6, 0);
    vt[20] = mk(1, 4'b1000, 4'b1000, 17'h00033, 0, 0, 0, 1);
    vt[21] = mk(1, 4'b0110, 4'b0010, 17'h00021, 0, 0, 0, 1);
    vt[22] = mk(1, 4'b0110, 4'b0100, 17'h00A5F, 1, 3, 4'h5, 1);
    vt[23] = mk(1, 4'b0110, 4'b0010, 17'h00021, 1, 1, 4'h7, 1);
    vt[24] = mk(1, 4'b0000, 4'b0000, 17'h00021, 1, 2, 4'h9, 1);
    vt[25] = mk(1, 4'b0000, 4'b0000, 17'h00021, 1, 1, 4'h7, 0);
    vt[26] = mk(1, 4'b0000, 4'b0000, 17'h00021, 0, 0, 0, 0);
    vt[27] = mk(0, 4'b0001, 4'b0000, 17'h00021, 0, 0, 0, 0);
    vt[28] = mk(1, 4'b0000, 4'b0000, 17'h00021, 0, 0, 0, 0);

    reset_n = 1'b0;
    en      = 1'b0;
    req     = '0;
    repeat (3) @(negedge vga_clk);
    chk("rst_gnt",   32'(gnt1),  32'h0);
    chk("rst_addr",  32'(addr1), 32'h0);
    chk("rst_vld",   32'(vld1),  32'h0);
    chk("rst_id",    32'(id1),   32'h0);
    chk("rst_data",  32'(dat1),  32'h0);
    chk("rst_busy",  32'(busy1), 32'h0);
    chk("rst3_vld",  32'(vld3),  32'h0);
    chk("rst3_busy", 32'(busy3), 32'h0);
    reset_n = 1'b1;

    // Table: idle after reset, single read, gnt mask, en gating, pairs.
    for (int i = 0; i < NV; i++) begin
      en  = vt[i].en;
      req = vt[i].req;
      @(negedge vga_clk);
      chk($sformatf("v%0d_gnt", i),  32'(gnt1),  32'(vt[i].gnt));
      chk($sformatf("v%0d_addr", i), 32'(addr1), 32'(vt[i].addr));
      chk($sformatf("v%0d_vld", i),  32'(vld1),  32'(vt[i].vld));
      chk($sformatf("v%0d_busy", i), 32'(busy1), 32'(vt[i].busy));
      if (vt[i].vld) begin
        chk($sformatf("v%0d_id", i),   32'(id1),  32'(vt[i].id));
        chk($sformatf("v%0d_data", i), 32'(dat1), 32'(vt[i].dat));
      end
    end

    // All four requesting continuously: grant order and returned tags.
    pulse_reset();
    req = 4'b1111;
    en  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge vga_clk);
      chk($sformatf("a%0d_gnt", k),  32'(gnt1),  32'(4'b0001 << seq_a[k]));
      chk($sformatf("a%0d_addr", k), 32'(addr1), 32'(addr_tab[seq_a[k]]));
      chk($sformatf("a%0d_busy", k), 32'(busy1), 32'h1);
      if (k >= 2) begin
        chk($sformatf("a%0d_vld", k),  32'(vld1), 32'h1);
        chk($sformatf("a%0d_id", k),   32'(id1),  32'(seq_a[k-2]));
        chk($sformatf("a%0d_data", k), 32'(dat1), 32'(dat_tab[seq_a[k-2]]));
      end else begin
        chk($sformatf("a%0d_vld", k), 32'(vld1), 32'h0);
      end
    end

    // ROM_LAT=3: three grants in flight, then en=0; all three still return.
    pulse_reset();
    for (int k = 0; k < 9; k++) begin
      case (k)
        0:       begin req = 4'b0111; en = 1'b1; end
        1:       begin req = 4'b0110; en = 1'b1; end
        2:       begin req = 4'b0100; en = 1'b1; end
        default: begin req = 4'b0111; en = 1'b0; end
      endcase
      @(negedge vga_clk);
      chk($sformatf("b%0d_gnt", k),  32'(gnt3),  (k < 3) ? 32'(4'b0001 << k) : 32'h0);
      chk($sformatf("b%0d_vld", k),  32'(vld3),  (k >= 4 && k <= 6) ? 32'h1 : 32'h0);
      chk($sformatf("b%0d_busy", k), 32'(busy3), (k <= 5) ? 32'h1 : 32'h0);
      if (k >= 4 && k <= 6) begin
        chk($sformatf("b%0d_id", k),   32'(id3),  32'(k - 4));
        chk($sformatf("b%0d_data", k), 32'(dat3), 32'(dat_tab[k-4]));
      end
    end

    // Reset pulse with two grants in flight.
    pulse_reset();
    req = 4'b0110;
    @(negedge vga_clk);
    chk("c0_gnt", 32'(gnt1), 32'h2);
    req = 4'b0100;
    @(negedge vga_clk);
    chk("c1_gnt", 32'(gnt1), 32'h4);
    req = 4'b0000;
    @(negedge vga_clk);
    chk("c2_vld", 32'(vld1), 32'h1);
    chk("c2_id",  32'(id1),  32'h1);
    reset_n = 1'b0;
    #1;
    chk("c_rst_vld",   32'(vld1),  32'h0);
    chk("c_rst_busy",  32'(busy1), 32'h0);
    chk("c_rst_gnt",   32'(gnt1),  32'h0);
    chk("c_rst3_busy", 32'(busy3), 32'h0);
    @(negedge vga_clk);
    reset_n = 1'b1;
    req     = 4'b1001;
    for (int k = 0; k < 6; k++) begin
      @(negedge vga_clk);
      if (k == 0) begin
        chk("r0_gnt",  32'(gnt1), 32'h1);
        chk("r0_gnt3", 32'(gnt3), 32'h1);
        req = 4'b0000;
      end
      chk($sformatf("r%0d_vld", k),  32'(vld1), (k == 2) ? 32'h1 : 32'h0);
      chk($sformatf("r%0d_vld3", k), 32'(vld3), (k == 4) ? 32'h1 : 32'h0);
      if (k == 2) chk("r2_id",  32'(id1), 32'h0);
      if (k == 4) chk("r4_id3", 32'(id3), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one sprite/background ROM and its palette lookup among up to NUM_REQ requesters, such as the player tank, enemy tanks and bullet renderers. It sits in the vga_clk domain between the per-object draw logic and the shared `*_rom` instance, which has a registered address. Each cycle it picks at most one requester by round-robin and drives that requester's address to the ROM. After the ROM latency it returns the ROM data tagged with the requester id.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 17, ROM address width
- DATA_W, 4, ROM word width (palette index)
- ROM_LAT, 1, vga_clk edges from rom_address change to matching rom_q (1..3)
- ID_W, $clog2(NUM_REQ), width of the requester tag (derived)

Ports:
- vga_clk  in  1  pixel clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  arbitration enable (e.g. blanking window); gates new grants only
- req  in  NUM_REQ  per-requester read request, level
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses slice [i*ADDR_W +: ADDR_W]
- gnt  out  NUM_REQ  one-hot grant, one-cycle pulse
- rom_address  out  ADDR_W  to the ROM address port
- rom_q  in  DATA_W  from the ROM
- rd_valid  out  1  rd_data/rd_id valid, one-cycle pulse per grant
- rd_id  out  ID_W  requester index of the returned word
- rd_data  out  DATA_W  registered ROM word
- busy  out  1  at least one read in flight (granted, rd_valid not yet issued)

## Operation
- All outputs are registered.
- Reset values: gnt=0, rom_address=0, rd_valid=0, rd_id=0, rd_data=0, busy=0, and the round-robin pointer last=NUM_REQ-1 (requester 0 wins first).
- Eligible set: req & ~gnt. The requester granted in the current cycle is masked, so a requester still holding req during its gnt cycle is not granted twice.
- Grant decision at each edge when en=1 and the eligible set is non-zero:
  - the winner is the first eligible index searching last+1, last+2, … modulo NUM_REQ;
  - gnt[winner] is set, rom_address is loaded with req_addr[winner], and last is set to winner.
- No grant when en=0 or the eligible set is empty:
  - gnt=0, and rom_address holds its value;
  - last is unchanged.
- Requester protocol:
  - hold req and req_addr stable until gnt is observed;
  - req may drop or change address in the cycle after gnt;
  - dropping req before gnt withdraws the request, with no side effects.
- Tag pipeline:
  - each grant pushes {valid=1, id} into a ROM_LAT+1 deep shift register;
  - at the output stage, rd_valid=valid, rd_id=id, and rd_data is loaded with rom_q sampled on the same edge.
- busy is the OR of the pipeline valid bits, including the gnt stage.
- en=0 mid-stream: in-flight reads still complete and return. en only blocks new grants.
- Asynchronous reset mid-stream: all in-flight reads are discarded and rd_valid drops immediately. No rd_valid is produced for pre-reset grants after reset is released.

## Timing
- Request visible in cycle C-1 → gnt and rom_address valid in cycle C (1 edge).
- ROM samples rom_address at the end of C. rom_q is valid in cycle C+ROM_LAT.
- rd_valid, rd_id and rd_data are valid in cycle C+ROM_LAT+1, so gnt→rd_valid is ROM_LAT+1 cycles.
- Throughput:
  - one grant per cycle across distinct requesters;
  - the same requester at most every second cycle, because of the gnt mask.
- Results return in grant order with no reordering. Requesters filter on rd_id.
- Fairness: with all NUM_REQ requesting continuously, each is granted at least once every NUM_REQ cycles.

## Configuration
- SPRITE_ARB_PRIO0_EN defined:
  - requester 0 (player tank) wins whenever it is eligible;
  - requesters 1..NUM_REQ-1 round-robin among themselves;
  - last is updated only on grants to 1..NUM_REQ-1, and requester 0 grants leave last unchanged.
  - Starvation of 1..N-1 is permitted only while requester 0 requests on alternate cycles.
- Not defined: pure round-robin over all NUM_REQ requesters as described above.

## Test plan
- Reset release, req=4'b0000, en=1 → gnt=0, rd_valid=0, busy=0, rom_address=0 for 10 cycles.
- ROM_LAT=1, req[2]=1 with addr 17'h00A5F for one cycle, ROM model returns 4'h9 → gnt=4'b0100 in the next cycle, rom_address=17'h00A5F, and rd_valid=1, rd_id=2, rd_data=4'h9 exactly 2 cycles after gnt; only one grant issued.
- req=4'b1111 held continuously, en=1, macro undefined → grant sequence 0,1,2,3,0,… with no gaps after the first; every requester's rd_valid appears with its own rd_id, in order.
- Same as above with SPRITE_ARB_PRIO0_EN → sequence 0,1,0,2,0,3,0,1…; the gnt mask forces alternation.
- Three grants in flight with ROM_LAT=3, then en=0 → no new gnt, and all three rd_valid pulses still arrive and busy falls after the last.
- Two grants in flight, then reset_n pulsed low for 1 cycle → rd_valid=0 immediately, no stale rd_valid after release, and the next grant goes to requester 0 if requesting.
